// File: rtl/beam_scan_controller.sv
// Beam-steering scan controller: sweeps delay_select over NUM_DIRS directions, integrates |beam_sample|
// per direction, then steers to the loudest one. Optional macro BEAM_SCAN_HYST_EN adds result hysteresis.
module beam_scan_controller #(
  parameter int NUM_DIRS = 4,
  parameter int SETTLE   = 16,
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             sample_valid,
  input  logic [18:0]      beam_sample,
  output logic [4:0]       delay_select,
  output logic [4:0]       best_dir,
  output logic [ACC_W-1:0] best_energy,
  output logic             busy,
  output logic             scan_done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [4:0]        LAST_DIR    = 5'(NUM_DIRS - 1);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [WIN_LOG2:0] WIN_LAST    = (WIN_LOG2+1)'((1 << WIN_LOG2) - 1);

  state_t            state_q;
  logic [4:0]        dir_q;
  logic [15:0]       settle_cnt_q;
  logic [WIN_LOG2:0] win_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  best_acc_q;
  logic [4:0]        best_idx_q;
  logic [4:0]        delay_select_q;
  logic [4:0]        best_dir_q;
  logic [ACC_W-1:0]  best_energy_q;

  logic [18:0]      abs_mag;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_d;
  logic             take_new;
  logic [4:0]       best_idx_d;
  logic [ACC_W-1:0] best_acc_d;
  logic             accept;

  // Two's-complement magnitude kept at 19 bits so -2^18 yields +2^18 rather than overflowing.
  assign abs_mag    = beam_sample[18] ? (~beam_sample + 19'd1) : beam_sample;
  assign acc_sum    = {1'b0, acc_q} + (ACC_W+1)'(abs_mag);
  assign acc_d      = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  assign take_new   = (dir_q == 5'd0) || (acc_q > best_acc_q);
  assign best_idx_d = take_new ? dir_q : best_idx_q;
  assign best_acc_d = take_new ? acc_q : best_acc_q;

`ifdef BEAM_SCAN_HYST_EN
  logic first_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    first_q <= 1'b1;
    else if (state_q == ST_DONE) first_q <= 1'b0;
  end

  // A new direction must beat the held energy by 1/8 before the bank is re-steered.
  assign accept = first_q || (best_idx_d == best_dir_q) ||
                  ({1'b0, best_acc_d} > ({1'b0, best_energy_q} + {1'b0, best_energy_q >> 3}));
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      dir_q          <= '0;
      settle_cnt_q   <= '0;
      win_cnt_q      <= '0;
      acc_q          <= '0;
      best_acc_q     <= '0;
      best_idx_q     <= '0;
      delay_select_q <= '0;
      best_dir_q     <= '0;
      best_energy_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dir_q          <= '0;
            delay_select_q <= '0;
            settle_cnt_q   <= '0;
            state_q        <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (SETTLE == 0) begin
            acc_q     <= '0;
            win_cnt_q <= '0;
            state_q   <= ST_ACCUM;
          end else if (sample_valid) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              acc_q     <= '0;
              win_cnt_q <= '0;
              state_q   <= ST_ACCUM;
            end else begin
              settle_cnt_q <= settle_cnt_q + 16'd1;
            end
          end
        end
        ST_ACCUM: begin
          if (sample_valid) begin
            acc_q <= acc_d;
            if (win_cnt_q == WIN_LAST) state_q <= ST_COMPARE;
            else                       win_cnt_q <= win_cnt_q + 1'b1;
          end
        end
        ST_COMPARE: begin
          best_acc_q <= best_acc_d;
          best_idx_q <= best_idx_d;
          if (dir_q == LAST_DIR) begin
            state_q <= ST_DONE;
            if (accept) begin
              best_dir_q     <= best_idx_d;
              best_energy_q  <= best_acc_d;
              delay_select_q <= best_idx_d;
            end else begin
              delay_select_q <= best_dir_q;
            end
          end else begin
            dir_q          <= dir_q + 5'd1;
            delay_select_q <= dir_q + 5'd1;
            settle_cnt_q   <= '0;
            state_q        <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          if (continuous) begin
            dir_q          <= '0;
            delay_select_q <= '0;
            settle_cnt_q   <= '0;
            state_q        <= ST_SETTLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign delay_select = delay_select_q;
  assign best_dir     = best_dir_q;
  assign best_energy  = best_energy_q;
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_ACCUM) || (state_q == ST_COMPARE);
  assign scan_done    = (state_q == ST_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed bench for beam_scan_controller: table of per-direction magnitudes with expected winners,
// plus hand-written sequences for busy start, continuous mode, async reset, hysteresis and saturation.
module tb_beam_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, continuous, sample_valid;
  logic [18:0] beam_sample;
  logic [4:0]  delay_select, best_dir;
  logic [31:0] best_energy;
  logic        busy, scan_done;
  logic [2:0]  dbg_state;

  logic        start2;
  logic [18:0] beam_sample2;
  logic [4:0]  delay_select2, best_dir2;
  logic [19:0] best_energy2;
  logic        busy2, scan_done2;
  logic [2:0]  dbg_state2;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int mag_q [4];
  bit neg = 1'b0;

  always #5 clk = ~clk;

  beam_scan_controller #(.NUM_DIRS(4), .SETTLE(2), .WIN_LOG2(2), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sample_valid(sample_valid), .beam_sample(beam_sample),
    .delay_select(delay_select), .best_dir(best_dir), .best_energy(best_energy),
    .busy(busy), .scan_done(scan_done), .dbg_state(dbg_state)
  );

  beam_scan_controller #(.NUM_DIRS(1), .SETTLE(0), .WIN_LOG2(3), .ACC_W(20)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .continuous(1'b0),
    .sample_valid(sample_valid), .beam_sample(beam_sample2),
    .delay_select(delay_select2), .best_dir(best_dir2), .best_energy(best_energy2),
    .busy(busy2), .scan_done(scan_done2), .dbg_state(dbg_state2)
  );

  always @(posedge clk) if (scan_done === 1'b1) done_cnt++;

  // Strobe every other cycle; sample magnitude follows the currently selected direction, sign alternates.
  initial begin
    sample_valid = 1'b0;
    beam_sample  = '0;
    forever begin
      @(negedge clk);
      sample_valid = ~sample_valid;
      if (sample_valid) begin
        beam_sample = neg ? 19'(-mag_q[delay_select[1:0]]) : 19'(mag_q[delay_select[1:0]]);
        neg = ~neg;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_mags(input int m0, input int m1, input int m2, input int m3);
    mag_q[0] = m0; mag_q[1] = m1; mag_q[2] = m2; mag_q[3] = m3;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (scan_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (scan_done !== 1'b1) begin
      failures++;
      $display("FAIL %s: scan_done not seen within 400 cycles", name);
    end
  endtask

  task automatic wait_accum(input logic [4:0] d, input string name);
    int n = 0;
    while (!(dbg_state == 3'd2 && delay_select == d) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(dbg_state == 3'd2 && delay_select == d)) begin
      failures++;
      $display("FAIL %s: ACCUM on dir %0d not reached, state %0d dir %0d", name, d, dbg_state, delay_select);
    end
  endtask

  task automatic sweep_expect(input string name, input int exp_dir, input int exp_en);
    int d0;
    d0 = done_cnt;
    pulse_start();
    check({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(name);
    check({name, "_dir"}, 64'(best_dir), 64'(exp_dir));
    check({name, "_energy"}, 64'(best_energy), 64'(exp_en));
    check({name, "_ds_done"}, 64'(delay_select), 64'(exp_dir));
    repeat (3) @(negedge clk);
    check({name, "_idle"}, 64'(dbg_state), 64'd0);
    check({name, "_ds_idle"}, 64'(delay_select), 64'(exp_dir));
    check({name, "_pulses"}, 64'(done_cnt), 64'(d0 + 1));
  endtask

  typedef struct packed {
    logic [15:0] m0, m1, m2, m3;
    logic [4:0]  dir;
    logic [31:0] en;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0;
    vecs[0] = '{16'd100, 16'd300, 16'd200, 16'd50,  5'd1, 32'd1200};
    vecs[1] = '{16'd500, 16'd500, 16'd500, 16'd500, 5'd0, 32'd2000};
    vecs[2] = '{16'd10,  16'd20,  16'd30,  16'd40,  5'd3, 32'd160};
    vecs[3] = '{16'd50,  16'd0,   16'd0,   16'd0,   5'd0, 32'd200};
    vecs[4] = '{16'd7,   16'd7,   16'd9,   16'd9,   5'd2, 32'd36};
    set_mags(0, 0, 0, 0);
    rst = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    continuous = 1'b0;
    beam_sample2 = 19'h40000;

    repeat (3) @(negedge clk);
    check("rst_ds", 64'(delay_select), 64'd0);
    check("rst_best_dir", 64'(best_dir), 64'd0);
    check("rst_best_energy", 64'(best_energy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(scan_done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_mags(int'(vecs[i].m0), int'(vecs[i].m1), int'(vecs[i].m2), int'(vecs[i].m3));
      sweep_expect($sformatf("vec%0d", i), int'(vecs[i].dir), int'(vecs[i].en));
    end

    // Start while busy must not restart the sweep.
    do_reset();
    set_mags(100, 300, 200, 50);
    pulse_start();
    wait_accum(5'd1, "busy_start_wait");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ds", 64'(delay_select), 64'd1);
    check("busy_start_busy", 64'(busy), 64'd1);
    wait_done("busy_start");
    check("busy_start_dir", 64'(best_dir), 64'd1);
    check("busy_start_energy", 64'(best_energy), 64'd1200);

    // Continuous sweeps, then drop continuous during dir 2 of the third sweep.
    repeat (3) @(negedge clk);
    continuous = 1'b1;
    pulse_start();
    wait_done("cont1");
    check("cont1_dir", 64'(best_dir), 64'd1);
    @(negedge clk);
    check("cont_restart_state", 64'(dbg_state), 64'd1);
    check("cont_restart_ds", 64'(delay_select), 64'd0);
    check("cont_hold_dir", 64'(best_dir), 64'd1);
    check("cont_hold_energy", 64'(best_energy), 64'd1200);
    wait_done("cont2");
    check("cont2_energy", 64'(best_energy), 64'd1200);
    @(negedge clk);
    wait_accum(5'd2, "cont3_wait");
    continuous = 1'b0;
    wait_done("cont3");
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    check("cont_end_idle", 64'(dbg_state), 64'd0);
    check("cont_end_ds", 64'(delay_select), 64'd1);
    repeat (100) @(negedge clk);
    check("cont_end_no_more", 64'(done_cnt), 64'(d0 + 1));

    // Asynchronous reset in the middle of ACCUM.
    pulse_start();
    wait_accum(5'd2, "rst_mid_wait");
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ds", 64'(delay_select), 64'd0);
    check("rst_mid_dir", 64'(best_dir), 64'd0);
    check("rst_mid_energy", 64'(best_energy), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    check("rst_mid_idle", 64'(dbg_state), 64'd0);

    // Result hysteresis across three single sweeps following a reset.
    set_mags(100, 250, 50, 50);
    sweep_expect("hyst1", 1, 1000);
    set_mags(100, 100, 100, 275);
`ifdef BEAM_SCAN_HYST_EN
    sweep_expect("hyst2", 1, 1000);
`else
    sweep_expect("hyst2", 3, 1100);
`endif
    set_mags(100, 100, 100, 300);
    sweep_expect("hyst3", 3, 1200);

    // Saturation on the single-direction, zero-settle instance.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int n = 0;
      while (scan_done2 !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("sat_done", 64'(scan_done2), 64'd1);
    check("sat_energy", 64'(best_energy2), 64'd1048575);
    check("sat_dir", 64'(best_dir2), 64'd0);
    check("sat_ds", 64'(delay_select2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beam_scan_controller.md
Name: beam_scan_controller

Overview:
- Sequences the 8-mic delay bank. Sweeps `delay_select` over every steering direction and measures the energy of the summed beam for each one.
- After the sweep, it latches the loudest direction and steers the bank to that direction.
- Sits between the PCM decimation/summing path and the delay bank. It drives the bank's `delay_select` and consumes the beamformed sum sample stream.

Parameters:
- NUM_DIRS, 4: number of directions swept, 0..NUM_DIRS-1; legal range 1..32.
- SETTLE, 16: valid samples discarded after each `delay_select` change, so the delay lines refill.
- WIN_LOG2, 8: energy window is 2^WIN_LOG2 valid samples per direction.
- ACC_W, 32: energy accumulator and `best_energy` width; saturating.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a sweep when not busy
- continuous  in  1  1 = restart a sweep automatically after each DONE
- sample_valid  in  1  one-cycle strobe per beamformed sample
- beam_sample  in  19  signed two's-complement sum of the delayed mic channels
- delay_select  out  5  direction applied to the delay bank
- best_dir  out  5  loudest direction of the last completed sweep
- best_energy  out  ACC_W  energy of `best_dir`
- busy  out  1  high in SETTLE, ACCUM and COMPARE
- scan_done  out  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters and accumulators cleared. Output reset values: `delay_select`=0, `best_dir`=0, `best_energy`=0, `busy`=0, `scan_done`=0.
- IDLE:
  - `start`=1 → dir=0, `delay_select`=0, settle_cnt=0, go to SETTLE on the next edge.
  - `start` while `busy` is ignored.
- SETTLE: count `sample_valid` strobes. After SETTLE strobes: clear acc and win_cnt, go to ACCUM. If SETTLE=0, go straight to ACCUM.
- ACCUM:
  - On each `sample_valid`: acc += |`beam_sample`|. The abs value is 19-bit unsigned, so -262144 maps to 262144.
  - acc saturates at 2^ACC_W-1 and never wraps.
  - After 2^WIN_LOG2 strobes, go to COMPARE.
- COMPARE (exactly 1 cycle; a `sample_valid` arriving in this cycle is ignored):
  - If dir==0 or acc > best_acc (strict), then best_acc=acc and best_idx=dir. Ties keep the lower index.
  - If dir==NUM_DIRS-1, go to DONE.
  - Otherwise dir+1, `delay_select`=dir+1, settle_cnt=0, go to SETTLE.
- DONE (1 cycle):
  - `best_dir`=best_idx, `best_energy`=best_acc, `delay_select`=best_idx, `scan_done`=1 for this cycle.
  - Then go to SETTLE with dir=0 if `continuous`=1, otherwise to IDLE.
  - In continuous mode, `delay_select` returns to 0 for the sweep. `best_dir` and `best_energy` hold until the next DONE.
- IDLE holds `delay_select`=`best_dir`, i.e. the bank stays steered to the last result.
- `best_dir` and `best_energy` update only in DONE. They are never partially updated mid-sweep.
- `delay_select` changes only on state-transition edges, never mid-window.
- Deasserting `continuous` mid-sweep: the current sweep completes, then the block goes to IDLE.
- `rst` asserted mid-sweep aborts immediately to the reset values; no `scan_done` is issued.
- NUM_DIRS=1: one window is measured and `best_dir`=0.

Optional Feature:
- Macro: BEAM_SCAN_HYST_EN.
- When defined, DONE updates `best_dir`/`best_energy` only if one of these holds:
  - this is the first sweep since reset, or
  - best_idx==`best_dir`, or
  - best_acc > `best_energy` + (`best_energy`>>3), evaluated at ACC_W+1 bits.
- Otherwise `best_dir`/`best_energy` are held, `delay_select` returns to the held `best_dir`, and `scan_done` still pulses. This suppresses steering jitter in continuous mode.
- When undefined, `best_dir` and `best_energy` are updated on every DONE unconditionally.

Test Plan:
- Reset mid-ACCUM (NUM_DIRS=4, sweep in progress, pull `rst` low) → all outputs 0 asynchronously, state IDLE, no `scan_done`.
- Single sweep, NUM_DIRS=4, SETTLE=2, WIN_LOG2=2, `beam_sample` constant magnitude {100, 300, 200, 50} per direction → `best_dir`=1, `best_energy`=1200, one `scan_done` pulse, `delay_select`=1 in IDLE.
- Saturation: ACC_W=20, `beam_sample`=-262144 for 8 samples → `best_energy`=1048575, with no wrap.
- Tie: all directions magnitude 500 → `best_dir`=0.
- Busy start and continuous mode: `start` pulse during ACCUM is ignored; `continuous`=1 → back-to-back sweeps with `scan_done` every sweep. Drop `continuous` during dir 2 → block finishes the sweep, then IDLE.
- BEAM_SCAN_HYST_EN: sweep 1 best dir 1 at 1000; sweep 2 dir 3 at 1100 → `best_dir` stays 1. Sweep 3 dir 3 at 1200 → `best_dir`=3, `best_energy`=1200.
